// File: rtl/video_pkg.sv
// Shared definitions for the video tile path: register map, CTRL/STATUS bits,
// fill FSM encoding and tile memory geometry.
package video_pkg;

    localparam logic [31:0] TILE_BASE_DEFAULT = 32'h0520_0000;
    localparam int          TILE_DEPTH        = 4096;
    localparam int          TILE_IDX_W        = $clog2(TILE_DEPTH);
    localparam int          VAL_W             = 6;
    localparam int          CNT_W             = TILE_IDX_W + 1;

    localparam logic [1:0] REG_DEST  = 2'd0;
    localparam logic [1:0] REG_COUNT = 2'd1;
    localparam logic [1:0] REG_VALUE = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    localparam int CTRL_START     = 0;
    localparam int CTRL_WAIT_VBL  = 1;
    localparam int CTRL_VALUE_INC = 2;
    localparam int CTRL_ABORT     = 3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VBL,
        ST_RUN,
        ST_DONE
    } fill_state_t;

endpackage

// File: rtl/tile_fill_engine.sv
// Streams CPU-programmed tile fills into the video write port, one tile per
// cycle, and forwards other CPU accesses to the video block when the port is free.
module tile_fill_engine
    import video_pkg::*;
#(
    parameter logic [31:0] TILE_BASE = TILE_BASE_DEFAULT,
    parameter logic [3:0]  REG_SEL   = 4'h4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic        vblank,
    output logic        vid_valid,
    output logic [3:0]  vid_wstrb,
    output logic [31:0] vid_addr,
    output logic [31:0] vid_wdata
);

    fill_state_t           r_state;
    logic [TILE_IDX_W-1:0] r_dest;
    logic [CNT_W-1:0]      r_count;
    logic [VAL_W-1:0]      r_value;
    logic                  r_done;
    logic                  r_vbl_prev;

    // Working copies describe the tile write currently on vid_* while in RUN.
    logic [TILE_IDX_W-1:0] r_addr;
    logic [VAL_W-1:0]      r_val;
    logic [CNT_W-1:0]      r_rem;
    logic                  r_inc;

    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic                  r_vid_valid;
    logic [3:0]            r_vid_wstrb;
    logic [31:0]           r_vid_addr;
    logic [31:0]           r_vid_wdata;

    logic                  w_busy;
    logic                  w_pending;
    logic                  w_sel_reg;
    logic                  w_vbl_rise;
    logic                  w_vid_free;
    logic                  w_reg_acc;
    logic                  w_reg_wr;
    logic                  w_pass_acc;
    logic                  w_ctrl_wr;
    logic                  w_start;
    logic                  w_abort;
    logic [TILE_IDX_W-1:0] w_addr_inc;
    logic [VAL_W-1:0]      w_val_inc;
    logic [31:0]           w_rd_data;

    fill_state_t           w_state_nxt;
    logic                  w_load;
    logic                  w_step;
    logic                  w_set_done;
    logic                  w_clr_done;
    logic                  w_tile_wr;
    logic [TILE_IDX_W-1:0] w_tile_idx;
    logic [VAL_W-1:0]      w_tile_val;

    logic                  w_unused;
    assign w_unused = ^{iomem_addr[31:24], iomem_addr[19:4], iomem_addr[1:0]};

    assign w_busy     = (r_state == ST_WAIT_VBL) || (r_state == ST_RUN);
    assign w_pending  = iomem_valid && !r_ready;
    assign w_sel_reg  = (iomem_addr[23:20] == REG_SEL);
    assign w_vbl_rise = vblank && !r_vbl_prev;

    // The port is taken in RUN and on the cycle a vblank edge launches the first tile.
    assign w_vid_free = (r_state != ST_RUN) && !((r_state == ST_WAIT_VBL) && w_vbl_rise);

    assign w_reg_acc  = w_pending && w_sel_reg;
    assign w_reg_wr   = w_reg_acc && (iomem_wstrb != 4'b0000);
    assign w_pass_acc = w_pending && !w_sel_reg && w_vid_free;
    assign w_ctrl_wr  = w_reg_wr && (iomem_addr[3:2] == REG_CTRL) && iomem_wstrb[0];
    assign w_start    = w_ctrl_wr && iomem_wdata[CTRL_START] && !iomem_wdata[CTRL_ABORT];
    assign w_abort    = w_ctrl_wr && iomem_wdata[CTRL_ABORT];

    assign w_addr_inc = r_addr + 1'b1;
    assign w_val_inc  = r_val + {{(VAL_W-1){1'b0}}, r_inc};

    always_comb begin
        case (iomem_addr[3:2])
            REG_DEST:  w_rd_data = {{(32-TILE_IDX_W){1'b0}}, r_dest};
            REG_COUNT: w_rd_data = {{(32-CNT_W){1'b0}}, r_count};
            REG_VALUE: w_rd_data = {{(32-VAL_W){1'b0}}, r_value};
            default:   w_rd_data = {30'b0, r_done, w_busy};
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_set_done  = 1'b0;
        w_clr_done  = 1'b0;
        w_tile_wr   = 1'b0;
        w_tile_idx  = r_addr;
        w_tile_val  = r_val;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                    w_set_done  = 1'b1;
                end
                // A start landing in the single DONE cycle is honoured rather than lost.
                if (w_start) begin
                    w_clr_done = 1'b1;
                    w_load     = 1'b1;
                    if (r_count == '0) begin
                        w_state_nxt = ST_DONE;
                    end else if (iomem_wdata[CTRL_WAIT_VBL]) begin
                        w_state_nxt = ST_WAIT_VBL;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_tile_wr   = 1'b1;
                        w_tile_idx  = r_dest;
                        w_tile_val  = r_value;
                    end
                end
            end
            ST_WAIT_VBL: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_vbl_rise) begin
                    w_state_nxt = ST_RUN;
                    w_tile_wr   = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_rem == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_step     = 1'b1;
                    w_tile_wr  = 1'b1;
                    w_tile_idx = w_addr_inc;
                    w_tile_val = w_val_inc;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_dest      <= '0;
            r_count     <= '0;
            r_value     <= '0;
            r_done      <= 1'b0;
            r_vbl_prev  <= 1'b0;
            r_addr      <= '0;
            r_val       <= '0;
            r_rem       <= '0;
            r_inc       <= 1'b0;
            r_ready     <= 1'b0;
            r_rdata     <= '0;
            r_vid_valid <= 1'b0;
            r_vid_wstrb <= '0;
            r_vid_addr  <= '0;
            r_vid_wdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_vbl_prev <= vblank;
            r_ready    <= w_reg_acc || w_pass_acc;
            r_rdata    <= w_reg_acc ? w_rd_data : '0;

            if (w_reg_wr && !w_busy) begin
                case (iomem_addr[3:2])
                    REG_DEST: begin
                        if (iomem_wstrb[0]) r_dest[7:0] <= iomem_wdata[7:0];
                        if (iomem_wstrb[1]) r_dest[TILE_IDX_W-1:8] <= iomem_wdata[TILE_IDX_W-1:8];
                    end
                    REG_COUNT: begin
                        if (iomem_wstrb[0]) r_count[7:0] <= iomem_wdata[7:0];
                        if (iomem_wstrb[1]) r_count[CNT_W-1:8] <= iomem_wdata[CNT_W-1:8];
                    end
                    REG_VALUE: begin
                        if (iomem_wstrb[0]) r_value <= iomem_wdata[VAL_W-1:0];
                    end
                    default: ;
                endcase
            end

            if (w_clr_done) begin
                r_done <= 1'b0;
            end else if (w_set_done) begin
                r_done <= 1'b1;
            end

            if (w_load) begin
                r_addr <= r_dest;
                r_val  <= r_value;
                r_rem  <= r_count;
                r_inc  <= iomem_wdata[CTRL_VALUE_INC];
            end else if (w_step) begin
                r_addr <= w_addr_inc;
                r_val  <= w_val_inc;
                r_rem  <= r_rem - 1'b1;
            end

            if (w_tile_wr) begin
                r_vid_valid <= 1'b1;
                r_vid_wstrb <= 4'b0001;
                r_vid_addr  <= TILE_BASE | {{(30-TILE_IDX_W){1'b0}}, w_tile_idx, 2'b00};
                r_vid_wdata <= {{(32-VAL_W){1'b0}}, w_tile_val};
            end else if (w_pass_acc && (iomem_wstrb != 4'b0000)) begin
                r_vid_valid <= 1'b1;
                r_vid_wstrb <= iomem_wstrb;
                r_vid_addr  <= iomem_addr;
                r_vid_wdata <= iomem_wdata;
            end else begin
                r_vid_valid <= 1'b0;
                r_vid_wstrb <= '0;
                r_vid_addr  <= '0;
                r_vid_wdata <= '0;
            end
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign vid_valid   = r_vid_valid;
    assign vid_wstrb   = r_vid_wstrb;
    assign vid_addr    = r_vid_addr;
    assign vid_wdata   = r_vid_wdata;

endmodule

// File: tb/tb_tile_fill_engine.sv
// Randomised and directed bench for tile_fill_engine; every vid_* write is
// captured and compared against a list of tile writes computed from the fill rules.
module tb_tile_fill_engine;

    localparam logic [31:0] REG_BASE  = 32'h0540_0000;
    localparam logic [31:0] TILE_BASE = 32'h0520_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        vblank;
    logic        vid_valid;
    logic [3:0]  vid_wstrb;
    logic [31:0] vid_addr;
    logic [31:0] vid_wdata;

    tile_fill_engine dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .vblank      (vblank),
        .vid_valid   (vid_valid),
        .vid_wstrb   (vid_wstrb),
        .vid_addr    (vid_addr),
        .vid_wdata   (vid_wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t  got_q[$];
    int   got_cyc[$];
    wr_t  exp_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   bad_idle  = 0;
    int   bad_ready = 0;
    logic prev_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Capture every write on the video port, plus port hygiene, #1 after each edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (vid_valid === 1'b1) begin
            got_q.push_back({vid_addr, vid_wdata, vid_wstrb});
            got_cyc.push_back(cyc);
        end else if (vid_addr !== '0 || vid_wdata !== '0 || vid_wstrb !== '0) begin
            bad_idle++;
        end
        if (iomem_ready === 1'b1 && prev_ready === 1'b1) bad_ready++;
        prev_ready = iomem_ready;
    end

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output int rcyc);
        int n;
        @(negedge clk);
        if (iomem_ready === 1'b1) @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wdata = d;
        iomem_wstrb = s;
        rd   = '0;
        rcyc = -1;
        n    = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            if (iomem_ready === 1'b1) begin
                rd   = iomem_rdata;
                rcyc = cyc;
                break;
            end
            n++;
        end
        if (rcyc < 0) check("bus_timeout", 32'd0, 32'd1);
        iomem_valid = 1'b0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        iomem_wstrb = '0;
    endtask

    task automatic reg_wr(input int idx, input logic [31:0] d, output int rcyc);
        logic [31:0] rd;
        bus(REG_BASE | 32'(idx * 4), d, 4'hF, rd, rcyc);
    endtask

    task automatic reg_rd(input int idx, output logic [31:0] rd);
        int rc;
        bus(REG_BASE | 32'(idx * 4), 32'h0, 4'h0, rd, rc);
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        for (int i = 0; i < 300; i++) begin
            reg_rd(3, st);
            if (st[0] == 1'b0) return;
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Reference: tile i of a fill goes to (dest+i) mod 4096 with value (value+i) mod 64 or value.
    task automatic model_fill(input int dest, input int count, input int value, input bit inc);
        for (int i = 0; i < count; i++) begin
            exp_q.push_back({TILE_BASE + 32'(((dest + i) % 4096) * 4),
                             32'(inc ? (value + i) % 64 : value), 4'b0001});
        end
    endtask

    task automatic compare(input string tag, input int start_cyc, input int n_contig);
        check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s[%0d].addr", tag, i), got_q[i].addr, exp_q[i].addr);
            check($sformatf("%s[%0d].data", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s[%0d].strb", tag, i), 32'(got_q[i].strb), 32'(exp_q[i].strb));
            if (i < n_contig)
                check($sformatf("%s[%0d].cycle", tag, i), 32'(got_cyc[i]), 32'(start_cyc + i));
        end
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic program_fill(input int dest, input int count, input int value);
        int rc;
        reg_wr(0, 32'(dest), rc);
        reg_wr(1, 32'(count), rc);
        reg_wr(2, 32'(value), rc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] junk;
        int rc, sc, dest, cnt, val, n_before;
        bit inc;

        reset = 1'b1; vblank = 1'b0;
        iomem_valid = 1'b0; iomem_addr = '0; iomem_wdata = '0; iomem_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_ready", 32'(iomem_ready), 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_vid_valid", 32'(vid_valid), 32'd0);
        check("rst_vid_addr", vid_addr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            reg_rd(i, rd);
            check($sformatf("rst_reg%0d", i), rd, 32'd0);
        end

        // Unused bits and byte strobes.
        reg_wr(2, 32'hFFFF_FFFF, rc);
        reg_rd(2, rd); check("value_unused_bits", rd, 32'h3F);
        reg_wr(1, 32'hFFFF_1000, rc);
        reg_rd(1, rd); check("count_unused_bits", rd, 32'h1000);

        // Basic fill.
        program_fill(10, 3, 5);
        got_q.delete(); got_cyc.delete();
        reg_wr(3, 32'h1, sc);
        wait_idle();
        model_fill(10, 3, 5, 1'b0);
        compare("basic", sc, 3);
        reg_rd(3, rd); check("basic_status", rd, 32'h2);
        reg_rd(0, rd); check("basic_dest_kept", rd, 32'd10);

        // Wrap of tile index and value.
        program_fill(4094, 4, 62);
        reg_wr(3, 32'h5, sc);
        wait_idle();
        model_fill(4094, 4, 62, 1'b1);
        compare("wrap", sc, 4);

        // Randomised fills, DEST written one byte lane at a time.
        for (int k = 0; k < 6; k++) begin
            dest = $urandom_range(0, 4095);
            cnt  = $urandom_range(1, 40);
            val  = $urandom_range(0, 63);
            inc  = 1'($urandom_range(0, 1));
            junk = $urandom;
            bus(REG_BASE, (junk & ~32'hFF) | (32'(dest) & 32'hFF), 4'b0001, rd, rc);
            junk = $urandom;
            bus(REG_BASE, (junk & ~32'hF00) | (32'(dest) & 32'hF00), 4'b0010, rd, rc);
            reg_rd(0, rd); check("rand_dest_bytes", rd, 32'(dest));
            reg_wr(1, 32'(cnt), rc);
            reg_wr(2, 32'(val), rc);
            reg_wr(3, 32'h1 | (32'(inc) << 2), sc);
            wait_idle();
            model_fill(dest, cnt, val, inc);
            compare($sformatf("rand%0d", k), sc, cnt);
            reg_rd(1, rd); check("rand_count_kept", rd, 32'(cnt));
        end

        // Vblank gating with vblank already high at start.
        @(negedge clk); vblank = 1'b1;
        program_fill(7, 3, 9);
        got_q.delete(); got_cyc.delete();
        reg_wr(3, 32'h3, rc);
        repeat (8) @(posedge clk);
        reg_rd(3, rd); check("vbl_status_busy", rd, 32'h1);
        reg_wr(0, 32'd55, rc);
        @(negedge clk); vblank = 1'b0;
        repeat (5) @(posedge clk);
        check("vbl_no_early_write", 32'(got_q.size()), 32'd0);
        @(negedge clk); vblank = 1'b1;
        @(posedge clk); #1;
        check("vbl_first_write", 32'(vid_valid), 32'd1);
        wait_idle();
        @(negedge clk); vblank = 1'b0;
        model_fill(7, 3, 9, 1'b0);
        compare("vbl", 0, 0);
        reg_rd(0, rd); check("vbl_dest_ignored_busy", rd, 32'd7);

        // Abort after two writes of a 100-tile fill.
        program_fill(300, 100, 20);
        got_q.delete(); got_cyc.delete();
        reg_wr(3, 32'h1, sc);
        reg_wr(3, 32'h8, rc);
        repeat (5) @(posedge clk);
        model_fill(300, 2, 20, 1'b0);
        compare("abort", sc, 2);
        reg_rd(3, rd); check("abort_status", rd, 32'h0);

        // Start and abort together: nothing happens.
        reg_wr(3, 32'h9, rc);
        repeat (5) @(posedge clk);
        check("start_abort_nwrites", 32'(got_q.size()), 32'd0);
        reg_rd(3, rd); check("start_abort_status", rd, 32'h0);

        // COUNT=0.
        reg_wr(1, 32'd0, rc);
        got_q.delete(); got_cyc.delete();
        reg_wr(3, 32'h1, rc);
        reg_rd(3, rd); check("count0_status", rd, 32'h2);
        check("count0_nwrites", 32'(got_q.size()), 32'd0);

        // Pass-through read and write while idle.
        bus(32'h0510_0000, 32'h0, 4'h0, rd, rc);
        check("pt_read_rdata", rd, 32'd0);
        check("pt_read_no_vid", 32'(vid_valid), 32'd0);
        bus(32'h0510_0008, 32'h1234_5678, 4'b0110, rd, rc);
        check("pt_idle_valid", 32'(vid_valid), 32'd1);
        check("pt_idle_addr", vid_addr, 32'h0510_0008);
        check("pt_idle_data", vid_wdata, 32'h1234_5678);
        check("pt_idle_strb", 32'(vid_wstrb), 32'h6);
        repeat (2) @(posedge clk);
        got_q.delete(); got_cyc.delete();

        // Pass-through write stalled behind a 50-tile fill.
        program_fill(100, 50, 3);
        got_q.delete(); got_cyc.delete();
        reg_wr(3, 32'h1, sc);
        bus(32'h0510_0004, 32'hDEAD_BEEF, 4'hF, rd, rc);
        check("stall_ready_cycle", 32'(rc), 32'(sc + 50 + 1));
        check("stall_vid_valid", 32'(vid_valid), 32'd1);
        wait_idle();
        model_fill(100, 50, 3, 1'b0);
        exp_q.push_back({32'h0510_0004, 32'hDEAD_BEEF, 4'hF});
        compare("stall", sc, 50);

        // Reset in the middle of a fill.
        program_fill(5, 30, 1);
        reg_wr(3, 32'h1, rc);
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_vid_valid", 32'(vid_valid), 32'd0);
        check("mid_rst_vid_addr", vid_addr, 32'd0);
        check("mid_rst_vid_data", vid_wdata, 32'd0);
        check("mid_rst_ready", 32'(iomem_ready), 32'd0);
        check("mid_rst_rdata", iomem_rdata, 32'd0);
        @(negedge clk); reset = 1'b0;
        n_before = got_q.size();
        repeat (10) @(posedge clk);
        check("mid_rst_no_more_writes", 32'(got_q.size()), 32'(n_before));
        for (int i = 0; i < 4; i++) begin
            reg_rd(i, rd);
            check($sformatf("mid_rst_reg%0d", i), rd, 32'd0);
        end

        repeat (2) @(posedge clk);
        check("vid_idle_zero", 32'(bad_idle), 32'd0);
        check("ready_one_cycle", 32'(bad_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tile_fill_engine.md
# tile_fill_engine

Bus-side fill engine placed between the PicoSoC iomem bus and the `video` peripheral's write port. The CPU programs a destination tile index, count and 6-bit tile value; the engine then streams one tile-memory write per cycle into the video block, optionally starting on the next vertical blank. CPU writes to other video addresses pass through unchanged when the engine is not running and are stalled while it is.

## Interface
Parameters:
- `TILE_BASE`, 32'h0520_0000, address of tile memory on the video write port.
- `REG_SEL`, 4'h4, value of `iomem_addr[23:20]` selecting this block's registers (0x0540_0000).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `iomem_valid`  in  1  CPU request.
- `iomem_ready`  out  1  one-cycle acknowledge.
- `iomem_wstrb`  in  4  byte strobes; 0 means read.
- `iomem_addr`  in  32  request address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data, valid while `iomem_ready` is high.
- `vblank`  in  1  level, high during vertical blank (from the video sync generator).
- `vid_valid`  out  1  write strobe into `video`.
- `vid_wstrb`  out  4  strobes into `video`.
- `vid_addr`  out  32  address into `video`.
- `vid_wdata`  out  32  data into `video`.

## Operation
- Registers, selected by `iomem_addr[3:2]` when `iomem_addr[23:20]==REG_SEL`:
  - 0 DEST[11:0]
  - 1 COUNT[12:0], range 0..4096
  - 2 VALUE[5:0]
  - 3 CTRL/STATUS
- CTRL write bits: 0 start, 1 wait_vblank, 2 value_inc, 3 abort.
- STATUS read bits: 0 busy, 1 done (sticky).
- Register writes honour byte strobes. Unused bits read as 0.
- While busy, writes to DEST, COUNT and VALUE are ignored. Reads are always serviced.
- FSM states:
  - IDLE: start=1 clears done. It goes to WAIT_VBL if wait_vblank=1, else to RUN. If COUNT==0 it goes to DONE directly.
  - WAIT_VBL: waits for a `vblank` rising edge, using a registered previous sample. It then goes to RUN. A vblank already high at start does not count.
  - RUN: issues one write per cycle:
    - `vid_valid`=1, `vid_wstrb`=4'b0001
    - `vid_addr`=TILE_BASE | {18'b0, addr, 2'b00}
    - `vid_wdata`={26'b0, val}
    - After each write, addr += 1 mod 4096 (wraps 4095 -> 0), val += 1 mod 64 if value_inc, and the remaining count decrements. The write issued with remaining==1 is the last; the FSM then goes to DONE.
  - DONE: one cycle. Sets done, then returns to IDLE.
- Working copies of addr, val and count are loaded at start. The DEST, COUNT and VALUE registers themselves are unchanged by a fill.
- busy = state is WAIT_VBL or RUN.
- abort=1 while busy: the FSM goes to IDLE the next cycle, no further writes are issued, and done is not set. start and abort written together: abort wins and the fill does not start.
- start while busy is ignored.
- Pass-through: a request with `iomem_addr[23:20]!=REG_SEL` is forwarded as one `vid_*` cycle with the CPU's addr, wdata and wstrb.
  - Forwarding happens only when the state is not RUN. In RUN the request waits, with ready low, until RUN exits.
  - Pass-through reads (wstrb==0) produce no `vid_valid` and return rdata 0.

## Timing
- Reset values: state IDLE; all registers, working copies, done, busy and the vblank sample are 0. All outputs (`iomem_ready`, `iomem_rdata`, `vid_*`) are 0.
- Register access: `iomem_ready` pulses high for exactly 1 cycle, in the cycle after `iomem_valid` is first seen. rdata is registered alongside it. The CPU holds valid until ready.
- Start latency: the CTRL write is registered in cycle N. RUN begins at N+1, with the first `vid_valid` in N+1.
- A fill of C tiles has `vid_valid` high for C consecutive cycles. DONE follows in the next cycle, and done reads 1 from the cycle after that.
- Pass-through: `vid_valid` and `iomem_ready` are asserted in the same cycle, one cycle after the request is accepted. At most one engine write or one pass-through write is on `vid_*` per cycle; they never coincide.
- `vid_*` are registered outputs and are all 0 when `vid_valid` is 0.

## Structure
- Shared package `video_pkg`:
  - register offsets, CTRL/STATUS bit positions
  - FSM state encoding (IDLE, WAIT_VBL, RUN, DONE)
  - TILE_BASE and the tile memory depth (4096)
- Single module, no sub-modules. The vblank edge detector is inline.
- In the top level, `vid_*` drive the `video` block's `iomem_valid`, `iomem_wstrb`, `iomem_addr` and `iomem_wdata` inputs.

## Test plan
- Basic fill: DEST=10, COUNT=3, VALUE=5, start -> three consecutive writes to 0x0520_0028/2C/30 with data 5, then done=1 and busy=0.
- Wrap and increment: DEST=4094, COUNT=4, VALUE=62, value_inc -> tile indices 4094, 4095, 0, 1 with data 62, 63, 0, 1.
- Vblank gating: wait_vblank with vblank already high -> no writes until vblank falls and rises again; first write lands 1 cycle after the rising edge is sampled.
- Edge cases: COUNT=0 start -> zero `vid_valid`, done=1 after 2 cycles. Abort after 2 of 100 writes -> exactly 2 writes, done=0, busy=0.
- Stall: CPU write to 0x0510_0004 during a 50-tile fill -> ready held low; forwarded unchanged exactly once, after the last fill write; no overlap on `vid_*`.
- Reset mid-RUN: `reset` high for 1 cycle during a fill -> next cycle all outputs 0, state IDLE, all registers 0.
